// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port DataMemory arbiter.
// DMEM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  localparam int unsigned NUM_PORTS = 2;
  localparam logic        PORT_CPU  = 1'b0;
  localparam logic        PORT_DBG  = 1'b1;

  // One-hot grant to port index; only the debug bit distinguishes the two ports
  function automatic logic grant_to_port(input logic [NUM_PORTS-1:0] grant);
    return grant[PORT_DBG];
  endfunction

endpackage

// File: rtl/dmem_arb_picker.sv
// Winner selection between the two request ports.
// DMEM_ARB_ROUND_ROBIN_EN: i_ptr is the last granted port and loses ties.
module dmem_arb_picker
  import dmem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] i_valid,
  input  logic                 i_ptr,
  output logic [NUM_PORTS-1:0] o_grant
);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // Tie goes to the port that was not granted last
  always_comb begin
    o_grant = 2'b00;
    if (i_valid == 2'b11) begin
      if (i_ptr == PORT_CPU) begin
        o_grant = 2'b10;
      end else begin
        o_grant = 2'b01;
      end
    end else begin
      o_grant = i_valid;
    end
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = i_ptr;

  // Fixed priority: CPU port always wins
  always_comb begin
    o_grant = 2'b00;
    if (i_valid[PORT_CPU]) begin
      o_grant[PORT_CPU] = 1'b1;
    end else begin
      o_grant[PORT_DBG] = i_valid[PORT_DBG];
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported DataMemory: IDLE -> ISSUE -> RESP.
// Build option DMEM_ARB_ROUND_ROBIN_EN enables round-robin arbitration.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_0,
  output logic              req_ready_0,
  input  logic              req_we_0,
  input  logic [ADDR_W-1:0] req_addr_0,
  input  logic [DATA_W-1:0] req_wdata_0,
  output logic              rsp_valid_0,
  output logic [DATA_W-1:0] rsp_rdata_0,
  input  logic              req_valid_1,
  output logic              req_ready_1,
  input  logic              req_we_1,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [DATA_W-1:0] req_wdata_1,
  output logic              rsp_valid_1,
  output logic [DATA_W-1:0] rsp_rdata_1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [DATA_W-1:0] mem_read_data
);

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic [NUM_PORTS-1:0] w_valid;
  logic [NUM_PORTS-1:0] w_grant;
  logic                 w_hs;
  logic                 w_hs_port;
  logic                 w_ptr;

  logic                 r_owner;
  logic                 r_we;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;

  logic                 r_rsp_valid_0;
  logic                 r_rsp_valid_1;
  logic [DATA_W-1:0]    r_rsp_rdata_0;
  logic [DATA_W-1:0]    r_rsp_rdata_1;

  assign w_valid   = {req_valid_1, req_valid_0};
  assign w_hs      = (r_state == IDLE) && (|w_grant);
  assign w_hs_port = grant_to_port(w_grant);

  dmem_arb_picker u_picker (
    .i_valid (w_valid),
    .i_ptr   (w_ptr),
    .o_grant (w_grant)
  );

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic r_last_grant;

  // Last-grant pointer, moves only on an accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b0;
    end else if (w_hs) begin
      r_last_grant <= w_hs_port;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

  assign w_ptr = r_last_grant;
`else
  assign w_ptr = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; ISSUE and RESP each last exactly one cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_hs) begin
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE:   w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: ready only in IDLE, memory controls only in ISSUE
  always_comb begin
    req_ready_0      = 1'b0;
    req_ready_1      = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready_0 = w_grant[PORT_CPU];
        req_ready_1 = w_grant[PORT_DBG];
      end
      ISSUE: begin
        mem_address = r_addr;
        if (r_we) begin
          mem_write_enable = 1'b1;
          mem_write_data   = r_wdata;
        end else begin
          mem_read_enable  = 1'b1;
        end
      end
      default: begin
        req_ready_0 = 1'b0;
        req_ready_1 = 1'b0;
      end
    endcase
  end

  // Request latch, loaded from the winning port on the handshake edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_hs) begin
      r_owner <= w_hs_port;
      if (w_hs_port == PORT_DBG) begin
        r_we    <= req_we_1;
        r_addr  <= req_addr_1;
        r_wdata <= req_wdata_1;
      end else begin
        r_we    <= req_we_0;
        r_addr  <= req_addr_0;
        r_wdata <= req_wdata_0;
      end
    end else begin
      r_owner <= r_owner;
      r_we    <= r_we;
      r_addr  <= r_addr;
      r_wdata <= r_wdata;
    end
  end

  // Response registers: read data captured at the end of ISSUE, pulse held for RESP only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid_0 <= 1'b0;
      r_rsp_valid_1 <= 1'b0;
      r_rsp_rdata_0 <= '0;
      r_rsp_rdata_1 <= '0;
    end else if (r_state == ISSUE) begin
      r_rsp_valid_0 <= (r_owner == PORT_CPU);
      r_rsp_valid_1 <= (r_owner == PORT_DBG);
      r_rsp_rdata_0 <= ((r_owner == PORT_CPU) && !r_we) ? mem_read_data : '0;
      r_rsp_rdata_1 <= ((r_owner == PORT_DBG) && !r_we) ? mem_read_data : '0;
    end else begin
      r_rsp_valid_0 <= 1'b0;
      r_rsp_valid_1 <= 1'b0;
      r_rsp_rdata_0 <= '0;
      r_rsp_rdata_1 <= '0;
    end
  end

  assign rsp_valid_0 = r_rsp_valid_0;
  assign rsp_valid_1 = r_rsp_valid_1;
  assign rsp_rdata_0 = r_rsp_rdata_0;
  assign rsp_rdata_1 = r_rsp_rdata_1;

endmodule
